// File: rtl/eeg_pea_eng_fdr.sv
// rtl/eeg_pea_eng_fdr.sv - activation/weight beat feeder for a convolution PE
//
// Reads CFG_ACT_LEN activations from ARAM and, for each one, emits CFG_CONV_WEI
// beats that pair it with weight bank entries 0..CFG_CONV_WEI-1.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   CFG_ACT_LEN, CFG_CONV_WEI   run configuration, captured when START is accepted
//   START, PE_IDLE              run request, accepted only while idle and PE_IDLE high
//   BUSY, DONE                  run in progress, one-cycle end-of-run pulse
//   WEI_WEN/WIDX/WDAT           weight bank write port, honoured only while idle
//   ARAM_REN/RADD/RDAT          activation RAM read port, data one cycle after REN
//   DIN_VLD/RDY                 beat handshake towards the PE
//   ACT_LST, WEI_LST            last activation / last weight index markers
//   ACT_DAT/ADD, WEI_DAT/IDX    beat payload
//
// Optional feature: define EEG_FDR_ZERO_SKIP_EN to drop zero activations
// (except the last address) before they reach the FIFO.
module eeg_pea_eng_fdr #(
    parameter int DATA_ACT_DW = 8,
    parameter int DATA_WEI_DW = 8,
    parameter int ARAM_ADD_AW = 10,
    parameter int CONV_WEI_DW = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ARAM_ADD_AW-1:0] CFG_ACT_LEN,
    input  logic [CONV_WEI_DW-1:0] CFG_CONV_WEI,
    input  logic                   START,
    input  logic                   PE_IDLE,
    output logic                   BUSY,
    output logic                   DONE,
    input  logic                   WEI_WEN,
    input  logic [CONV_WEI_DW-1:0] WEI_WIDX,
    input  logic [DATA_WEI_DW-1:0] WEI_WDAT,
    output logic                   ARAM_REN,
    output logic [ARAM_ADD_AW-1:0] ARAM_RADD,
    input  logic [DATA_ACT_DW-1:0] ARAM_RDAT,
    output logic                   DIN_VLD,
    input  logic                   DIN_RDY,
    output logic                   ACT_LST,
    output logic                   WEI_LST,
    output logic [DATA_ACT_DW-1:0] ACT_DAT,
    output logic [ARAM_ADD_AW-1:0] ACT_ADD,
    output logic [DATA_WEI_DW-1:0] WEI_DAT,
    output logic [CONV_WEI_DW-1:0] WEI_IDX
);

    localparam int WDEPTH = 1 << CONV_WEI_DW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ARAM_ADD_AW-1:0] len_r;
    logic [ARAM_ADD_AW-1:0] rd_cnt;
    logic [ARAM_ADD_AW-1:0] flight_add;
    logic                   flight;
    logic [CONV_WEI_DW-1:0] wei_r;
    logic [CONV_WEI_DW-1:0] wei_idx;
    logic [DATA_WEI_DW-1:0] bank [WDEPTH];
    logic [DATA_ACT_DW-1:0] fifo_dat [2];
    logic [ARAM_ADD_AW-1:0] fifo_add [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             count;
    logic                   done_r;

    logic       accept;
    logic       ren;
    logic       last_rd;
    logic       vld;
    logic       hs;
    logic       wlst;
    logic       alst;
    logic       pop;
    logic       push;
    logic       last_hs;
    logic [1:0] occ;

    assign accept  = (state == S_IDLE) && START && PE_IDLE;
    // A read in flight already owns a FIFO slot, so it counts toward occupancy.
    assign occ     = count + 2'(flight);
    assign ren     = (state == S_RUN) && (rd_cnt < len_r) && (occ < 2'd2);
    assign last_rd = ren && (rd_cnt == len_r - ARAM_ADD_AW'(1));
    assign vld     = (count != 2'd0);
    assign hs      = vld && DIN_RDY;
    assign wlst    = (wei_idx == wei_r - CONV_WEI_DW'(1));
    assign alst    = (fifo_add[rd_ptr] == len_r - ARAM_ADD_AW'(1));
    assign pop     = hs && wlst;
    assign last_hs = hs && wlst && alst;

`ifdef EEG_FDR_ZERO_SKIP_EN
    // The last address is always kept so the run still ends on a marked beat.
    assign push = flight && ((ARAM_RDAT != '0) || (flight_add == len_r - ARAM_ADD_AW'(1)));
`else
    assign push = flight;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && (CFG_ACT_LEN != '0)) state_nxt = S_RUN;
            S_RUN:   if (last_rd) state_nxt = S_DRAIN;
            S_DRAIN: if (last_hs) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        BUSY      = (state != S_IDLE);
        DONE      = done_r;
        ARAM_REN  = ren;
        ARAM_RADD = ren ? rd_cnt : '0;
        DIN_VLD   = vld;
        ACT_LST   = vld && alst;
        WEI_LST   = vld && wlst;
        ACT_DAT   = fifo_dat[rd_ptr];
        ACT_ADD   = fifo_add[rd_ptr];
        WEI_DAT   = bank[wei_idx];
        WEI_IDX   = wei_idx;
    end

    // Datapath: configuration, read issue, FIFO and weight sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r      <= '0;
            wei_r      <= '0;
            rd_cnt     <= '0;
            flight     <= 1'b0;
            flight_add <= '0;
            wei_idx    <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            done_r     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_dat[i] <= '0;
                fifo_add[i] <= '0;
            end
            for (int i = 0; i < WDEPTH; i++) begin
                bank[i] <= '0;
            end
        end else begin
            done_r <= (accept && (CFG_ACT_LEN == '0)) || ((state == S_DRAIN) && last_hs);

            if (accept) begin
                len_r   <= CFG_ACT_LEN;
                wei_r   <= (CFG_CONV_WEI == '0) ? CONV_WEI_DW'(1) : CFG_CONV_WEI;
                rd_cnt  <= '0;
                wei_idx <= '0;
            end

            if ((state == S_IDLE) && WEI_WEN) begin
                bank[WEI_WIDX] <= WEI_WDAT;
            end

            if (ren) begin
                rd_cnt <= rd_cnt + ARAM_ADD_AW'(1);
            end
            flight     <= ren;
            flight_add <= rd_cnt;

            if (push) begin
                fifo_dat[wr_ptr] <= ARAM_RDAT;
                fifo_add[wr_ptr] <= flight_add;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);

            if (hs) begin
                wei_idx <= wlst ? '0 : wei_idx + CONV_WEI_DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_eeg_pea_eng_fdr.sv
// tb/tb_eeg_pea_eng_fdr.sv - scoreboard bench for eeg_pea_eng_fdr
module tb_eeg_pea_eng_fdr;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] CFG_ACT_LEN;
    logic [2:0] CFG_CONV_WEI;
    logic       START, PE_IDLE, BUSY, DONE;
    logic       WEI_WEN;
    logic [2:0] WEI_WIDX;
    logic [7:0] WEI_WDAT;
    logic       ARAM_REN;
    logic [9:0] ARAM_RADD;
    logic [7:0] ARAM_RDAT = 8'd0;
    logic       DIN_VLD, DIN_RDY, ACT_LST, WEI_LST;
    logic [7:0] ACT_DAT;
    logic [9:0] ACT_ADD;
    logic [7:0] WEI_DAT;
    logic [2:0] WEI_IDX;

    always #5 clk = ~clk;

    eeg_pea_eng_fdr dut (
        .clk(clk), .rst(rst),
        .CFG_ACT_LEN(CFG_ACT_LEN), .CFG_CONV_WEI(CFG_CONV_WEI),
        .START(START), .PE_IDLE(PE_IDLE), .BUSY(BUSY), .DONE(DONE),
        .WEI_WEN(WEI_WEN), .WEI_WIDX(WEI_WIDX), .WEI_WDAT(WEI_WDAT),
        .ARAM_REN(ARAM_REN), .ARAM_RADD(ARAM_RADD), .ARAM_RDAT(ARAM_RDAT),
        .DIN_VLD(DIN_VLD), .DIN_RDY(DIN_RDY), .ACT_LST(ACT_LST), .WEI_LST(WEI_LST),
        .ACT_DAT(ACT_DAT), .ACT_ADD(ACT_ADD), .WEI_DAT(WEI_DAT), .WEI_IDX(WEI_IDX)
    );

    typedef struct packed {
        logic [7:0] act;
        logic [9:0] add;
        logic [7:0] wei;
        logic [2:0] idx;
        logic       alst;
        logic       wlst;
    } beat_t;

    logic [7:0] mem [0:1023];
    logic [7:0] bank_m [8];
    beat_t      sb [$];

    int  tests = 0;
    int  fails = 0;
    int  cur_len = 0;
    int  reads = 0;
    int  pops = 0;
    int  hs_cnt = 0;
    int  rdy_mode = 0;
    bit  len0_ok = 0;
    bit  last_hs_prev = 0;
    bit  prev_stall = 0;
    beat_t prev_beat;

    // ARAM: data returned one cycle after the read enable
    always @(posedge clk) if (ARAM_REN) ARAM_RDAT <= mem[ARAM_RADD];

    function automatic beat_t cur_beat();
        return {ACT_DAT, ACT_ADD, WEI_DAT, WEI_IDX, ACT_LST, WEI_LST};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // PE ready pattern generator
    initial begin
        DIN_RDY = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       DIN_RDY = 1'b1;
                1:       DIN_RDY = ~DIN_RDY;
                default: DIN_RDY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and watches the protocol
    initial begin
        beat_t exp_b;
        bit exp_done;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_hs_prev = 0;
                prev_stall   = 0;
                len0_ok      = 0;
                continue;
            end
            exp_done = last_hs_prev || len0_ok;
            if (DONE || exp_done) begin
                check("done_pulse", DONE, exp_done);
                if (exp_done) check("busy_at_done", BUSY, 0);
            end
            last_hs_prev = 0;
            len0_ok      = 0;
            if (prev_stall) begin
                check("stall_vld", DIN_VLD, 1);
                check("stall_fields", cur_beat(), prev_beat);
            end
            if (ARAM_REN) begin
                check("aram_space", (reads - pops) <= 1, 1);
                check("aram_addr", ARAM_RADD, reads);
`ifdef EEG_FDR_ZERO_SKIP_EN
                if (mem[ARAM_RADD] == 8'd0 && int'(ARAM_RADD) != cur_len - 1) pops++;
`endif
                reads++;
            end
            if (DIN_VLD && DIN_RDY) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL beat_extra: got %0h expected none", cur_beat());
                end else begin
                    exp_b = sb.pop_front();
                    check("beat", cur_beat(), exp_b);
                end
                if (WEI_LST) pops++;
                if (ACT_LST && WEI_LST) last_hs_prev = 1;
            end
            prev_stall = DIN_VLD && !DIN_RDY;
            prev_beat  = cur_beat();
        end
    end

    task automatic write_bank();
        for (int i = 0; i < 8; i++) begin
            WEI_WEN  = 1'b1;
            WEI_WIDX = 3'(i);
            WEI_WDAT = 8'($urandom);
            bank_m[i] = WEI_WDAT;
            @(posedge clk); #1;
        end
        WEI_WEN = 1'b0;
    endtask

    task automatic expect_run(input int len, input int w);
        int we;
        beat_t b;
        we = (w == 0) ? 1 : w;
        for (int a = 0; a < len; a++) begin
`ifdef EEG_FDR_ZERO_SKIP_EN
            if (mem[a] == 8'd0 && a != len - 1) continue;
`endif
            for (int i = 0; i < we; i++) begin
                b.act  = mem[a];
                b.add  = 10'(a);
                b.wei  = bank_m[i];
                b.idx  = 3'(i);
                b.alst = (a == len - 1);
                b.wlst = (i == we - 1);
                sb.push_back(b);
            end
        end
    endtask

    task automatic run(input int len, input int w, input int mode, input bit wr_busy);
        int lat, n;
        bit first_kept;
        rdy_mode = mode;
        // START without PE_IDLE must be ignored
        PE_IDLE = 1'b0;
        START   = 1'b1;
        CFG_ACT_LEN  = 10'(len);
        CFG_CONV_WEI = 3'(w);
        @(posedge clk); #1;
        check("start_no_pe_idle", BUSY, 0);
        expect_run(len, w);
        cur_len = len;
        reads   = 0;
        pops    = 0;
        hs_cnt  = 0;
        PE_IDLE = 1'b1;
        @(posedge clk); #1;
        START = 1'b0;
        // configuration changes after acceptance must not matter
        CFG_ACT_LEN  = 10'($urandom_range(0, 15));
        CFG_CONV_WEI = 3'($urandom);
        if (len == 0) begin
            len0_ok = 1;
            check("len0_busy", BUSY, 0);
        end else begin
            check("busy_after_start", BUSY, 1);
            first_kept = 1;
`ifdef EEG_FDR_ZERO_SKIP_EN
            first_kept = (mem[0] != 8'd0) || (len == 1);
`endif
            lat = 1;
            while (!DIN_VLD && lat < 50) begin
                if (lat == 1 && wr_busy) begin
                    WEI_WEN  = 1'b1;
                    WEI_WIDX = 3'd0;
                    WEI_WDAT = ~bank_m[0];
                    START    = 1'b1;
                end
                @(posedge clk); #1;
                WEI_WEN = 1'b0;
                START   = 1'b0;
                lat++;
            end
            if (first_kept) check("first_beat_latency", lat, 3);
        end
        n = 0;
        while ((sb.size() != 0 || BUSY || DONE) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("run_timeout", n < 3000, 1);
        check("sb_drained", sb.size(), 0);
        check("reads_count", reads, len);
        sb.delete();
    endtask

    task automatic fill_mem(input int len);
        for (int a = 0; a < len; a++)
            mem[a] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        CFG_ACT_LEN = '0; CFG_CONV_WEI = '0; START = 0; PE_IDLE = 0;
        WEI_WEN = 0; WEI_WIDX = '0; WEI_WDAT = '0;
        for (int i = 0; i < 8; i++) bank_m[i] = 8'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {BUSY, DONE, ARAM_REN, ARAM_RADD, DIN_VLD, ACT_LST, WEI_LST,
                                ACT_DAT, ACT_ADD, WEI_DAT, WEI_IDX}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        write_bank();
        for (int i = 0; i < 4; i++) mem[i] = 8'(i + 1);
        run(4, 3, 0, 1);
        run(4, 3, 1, 0);
        run(0, 3, 0, 0);
        fill_mem(2);
        run(2, 0, 2, 0);
        mem[0] = 8'd5; mem[1] = 8'd0; mem[2] = 8'd0; mem[3] = 8'd0;
        run(4, 2, 2, 0);

        for (int k = 0; k < 8; k++) begin
            if (k % 3 == 0) write_bank();
            n = $urandom_range(1, 12);
            fill_mem(n);
            run(n, int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        // reset in the middle of a run
        for (int a = 0; a < 10; a++) mem[a] = 8'(a + 3);
        rdy_mode = 0;
        expect_run(10, 3);
        cur_len = 10; reads = 0; pops = 0; hs_cnt = 0;
        CFG_ACT_LEN = 10'd10; CFG_CONV_WEI = 3'd3; PE_IDLE = 1; START = 1;
        @(posedge clk); #1;
        START = 0;
        n = 0;
        while (hs_cnt < 5 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("midrun_beats", hs_cnt >= 5, 1);
        rst = 1'b1;
        #1;
        check("midrun_reset_outputs", {BUSY, DONE, ARAM_REN, ARAM_RADD, DIN_VLD, ACT_LST, WEI_LST,
                                       ACT_DAT, ACT_ADD, WEI_DAT, WEI_IDX}, 0);
        sb.delete();
        for (int i = 0; i < 8; i++) bank_m[i] = 8'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("no_done_after_reset", DONE, 0);
        fill_mem(6);
        run(6, 3, 2, 0);
        write_bank();
        run(5, 4, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
